div_unit: RTL and testbench

- Multi-cycle 32-bit signed/unsigned divider serving DIV/DIVU for the execute stage.
- The execute stage is the initiator: it raises a start request, holds operands, and stalls the pipeline.
- div_unit is the responder: it returns {remainder, quotient} plus a ready flag. The execute stage forwards the result to the HI/LO write request (HI = remainder, LO = quotient).

---
 rtl/div_unit_pkg.sv | 20 ++
 rtl/div_unit.sv | 170 +++++++++++++++++
 tb/tb_div_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings,
// handshake levels and the execute-stage ALU opcodes that select it.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider for the execute stage.
// Returns {remainder, quotient} with a ready flag held until start drops.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Two's-complement negate when requested; used for operand magnitudes
    // and for the final sign correction.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? (-v) : v;
    endfunction

    div_state_e         r_state;
    div_state_e         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_fin;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_request;
    logic               w_div_zero;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_sub;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quot_step;
    logic               w_last;
    logic               w_unused_bits;

    assign w_request  = (start_i == DivStart) && !annul_i;
    assign w_div_zero = (opdata2_i == '0);
    assign w_op1_neg  = signed_div_i & opdata1_i[WIDTH-1];
    assign w_op2_neg  = signed_div_i & opdata2_i[WIDTH-1];

    // One restoring step: shift in the next dividend bit, trial-subtract the
    // divisor; the sign bit of the widened difference is the borrow.
    assign w_shift     = {r_rem, r_dividend[WIDTH-1]};
    assign w_sub       = {1'b0, w_shift} - {2'b00, r_divisor};
    assign w_borrow    = w_sub[WIDTH+1];
    // Partial remainder stays below the divisor, so the dropped top bits are zero.
    assign w_rem_step  = w_borrow ? w_shift[WIDTH-1:0] : w_sub[WIDTH-1:0];
    assign w_quot_step = {r_quot[WIDTH-2:0], ~w_borrow};
    assign w_last      = (r_cnt == LAST_STEP);
    assign w_unused_bits = w_sub[WIDTH] ^ w_shift[WIDTH];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DivFree;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DivFree: begin
                if (w_request) begin
                    w_state_next = w_div_zero ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                w_state_next = annul_i ? DivFree : DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    w_state_next = DivFree;
                end else if (w_last) begin
                    w_state_next = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    w_state_next = DivFree;
                end
            end
            default: w_state_next = DivFree;
        endcase
    end

    // Operand capture, iteration datapath and registered result/ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_fin      <= '0;
            r_result   <= '0;
            r_ready    <= DivResultNotReady;
        end else begin
            case (r_state)
                DivFree: begin
                    r_result <= '0;
                    r_ready  <= DivResultNotReady;
                    if (w_request && !w_div_zero) begin
                        r_dividend <= cond_neg(opdata1_i, w_op1_neg);
                        r_divisor  <= cond_neg(opdata2_i, w_op2_neg);
                        r_neg_q    <= w_op1_neg ^ w_op2_neg;
                        r_neg_r    <= w_op1_neg;
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_quot     <= '0;
                    end
                end
                DivByZero: begin
                    r_fin <= '0;
                end
                DivOn: begin
                    if (!annul_i) begin
                        r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
                        r_rem      <= w_rem_step;
                        r_quot     <= w_quot_step;
                        r_cnt      <= r_cnt + CNT_ONE;
                        if (w_last) begin
                            r_fin <= {cond_neg(w_rem_step, r_neg_r),
                                      cond_neg(w_quot_step, r_neg_q)};
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStart) begin
                        r_result <= r_fin;
                        r_ready  <= DivResultReady;
                    end else begin
                        r_result <= '0;
                        r_ready  <= DivResultNotReady;
                    end
                end
                default: begin
                    r_ready <= DivResultNotReady;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, corner-case sequences
// and randomized requests against a plain-arithmetic reference model.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer division in 64 bits, truncating toward zero,
    // keeping the low 32 bits of each part; divide by zero yields zero.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Full handshake: request, scramble operands after acceptance, measure
    // latency, check hold while start stays high, then drop start.
    task automatic run_div(input string name, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        int lat;
        @(negedge clk);
        signed_div_i = sd;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        signed_div_i = ~sd;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = n;
                break;
            end
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, result_o, exp_res);
        repeat (3) @(posedge clk);
        #1;
        check({name, " ready hold"}, {63'h0, ready_o}, 64'h1);
        check({name, " result hold"}, result_o, exp_res);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " ready drop"}, {63'h0, ready_o}, 64'h0);
        check({name, " result drop"}, result_o, 64'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   saw;
        logic sd;
        logic [31:0] a, b;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
        vecs[3] = '{1'b0, 32'd1234,       32'd0,        64'h0,                 2};
        vecs[4] = '{1'b1, 32'd1234,       32'd0,        64'h0,                 2};
        vecs[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33};
        vecs[7] = '{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC, 33};
        vecs[8] = '{1'b0, 32'd0,          32'd5,        64'h0,                 33};
        vecs[9] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33};

        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        #12;
        check("reset ready", {63'h0, ready_o}, 64'h0);
        check("reset result", result_o, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].sd, vecs[i].a, vecs[i].b,
                    vecs[i].exp_res, vecs[i].exp_lat);
        end

        // Annul during the 10th busy cycle, then start+annul together in idle.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        saw = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) saw++;
        end
        check("annul no ready", 64'(saw), 64'h0);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // Annul in the divide-by-zero state returns to idle with no ready.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1234; opdata2_i = 32'd0; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        saw = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) saw++;
        end
        check("annul byzero no ready", 64'(saw), 64'h0);

        // Asynchronous reset while busy.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1234; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst mid-on ready", {63'h0, ready_o}, 64'h0);
        check("rst mid-on result", result_o, 64'h0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset while the result is presented.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        saw = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                saw = 1;
                break;
            end
        end
        check("pre-reset ready seen", 64'(saw), 64'h1);
        #1;
        rst = 1'b0;
        #1;
        check("rst in end ready", {63'h0, ready_o}, 64'h0);
        check("rst in end result", result_o, 64'h0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div("after reset 50/5", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 33);

        // Randomized requests against the reference model.
        for (int i = 0; i < 120; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            run_div($sformatf("rand%0d", i), sd, a, b, model(sd, a, b), (b == 32'h0) ? 2 : 33);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
